// File: rtl/grid_video_gen.sv
// grid_video_gen: runtime-programmable raster timing that draws a GRID_W x GRID_H cell bitmap and a blinking cursor.
// Pipeline: counter state -> stage 0 decode -> stage 1 colour/pins (two clocks, all outputs aligned).
module grid_video_gen #(
  parameter int            TW          = 12,
  parameter int            GRID_W      = 40,
  parameter int            GRID_H      = 25,
  parameter int            CELL_LOG2   = 4,
  parameter int            BLINK_FR    = 30,
  parameter logic          SYNC_POL    = 1'b1,
  parameter logic [23:0]   C_ALIVE     = 24'hFFFFFF,
  parameter logic [23:0]   C_DEAD      = 24'h000000,
  parameter logic [23:0]   C_BG        = 24'h202020,
  parameter logic [23:0]   C_CURS      = 24'hFF0000,
  parameter logic [TW-1:0] RST_H_TOTAL = TW'(799),
  parameter logic [TW-1:0] RST_H_SYNC  = TW'(95),
  parameter logic [TW-1:0] RST_H_START = TW'(141),
  parameter logic [TW-1:0] RST_H_END   = TW'(781),
  parameter logic [TW-1:0] RST_V_TOTAL = TW'(524),
  parameter logic [TW-1:0] RST_V_SYNC  = TW'(1),
  parameter logic [TW-1:0] RST_V_START = TW'(34),
  parameter logic [TW-1:0] RST_V_END   = TW'(514)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [TW-1:0]            h_total,
  input  logic [TW-1:0]            h_sync,
  input  logic [TW-1:0]            h_start,
  input  logic [TW-1:0]            h_end,
  input  logic [TW-1:0]            v_total,
  input  logic [TW-1:0]            v_sync,
  input  logic [TW-1:0]            v_start,
  input  logic [TW-1:0]            v_end,
  input  logic                     timing_load,
  input  logic [GRID_W*GRID_H-1:0] vecteur_map,
  input  logic [TW-1:0]            cursor_x,
  input  logic [TW-1:0]            cursor_y,
  input  logic                     cursor_en,
  output logic                     vga_hs,
  output logic                     vga_vs,
  output logic                     vga_de,
  output logic [7:0]               vga_r,
  output logic [7:0]               vga_g,
  output logic [7:0]               vga_b,
  output logic                     frame_start,
  output logic                     timing_busy
);

  localparam int MAP_N = GRID_W * GRID_H;
  localparam int IW    = (MAP_N > 1) ? $clog2(MAP_N) : 1;
  localparam int BW    = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [TW-1:0] GW_T       = TW'(GRID_W);
  localparam logic [TW-1:0] GH_T       = TW'(GRID_H);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FR - 1);

  typedef struct packed {
    logic [TW-1:0] ht, hs, hb, he, vt, vs, vb, ve;
  } timing_t;

  localparam timing_t TIMING_RST = {RST_H_TOTAL, RST_H_SYNC, RST_H_START, RST_H_END,
                                    RST_V_TOTAL, RST_V_SYNC, RST_V_START, RST_V_END};

  timing_t          act_r, pend_r, in_s;
  logic             busy_r;
  logic [TW-1:0]    h_cnt_r, v_cnt_r;
  logic [MAP_N-1:0] map_r;
  logic [BW-1:0]    blink_cnt_r;
  logic             phase_r;
  logic             wrap_s;

  logic [TW-1:0]        x_s, y_s, col_s, row_s;
  logic [IW-1:0]        idx_s;
  logic [CELL_LOG2-1:0] x_lo_s, y_lo_s;
  logic                 hs_s, vs_s, de_s, fs_s, in_grid_s, alive_s, edge_s, curs_s;

  logic        hs0_r, vs0_r, de0_r, fs0_r, curs0_r, grid0_r, alive0_r;
  logic [23:0] rgb_s;

  assign in_s   = {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end};
  assign wrap_s = (h_cnt_r == act_r.ht) && (v_cnt_r == act_r.vt);
  assign timing_busy = busy_r;

  // Raster counters, shadow timing swap, map snapshot and blink phase; all frame-boundary work happens at wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r     <= {TW{1'b0}};
      v_cnt_r     <= {TW{1'b0}};
      act_r       <= TIMING_RST;
      pend_r      <= {($bits(timing_t)){1'b0}};
      busy_r      <= 1'b0;
      map_r       <= {MAP_N{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b1;
    end else begin
      if (h_cnt_r == act_r.ht) begin
        h_cnt_r <= {TW{1'b0}};
        if (v_cnt_r == act_r.vt) v_cnt_r <= {TW{1'b0}};
        else                     v_cnt_r <= v_cnt_r + TW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + TW'(1);
      end
      if (wrap_s && busy_r) act_r <= pend_r;
      // A load on the wrap cycle itself stays pending for the following frame.
      if (timing_load) begin
        pend_r <= in_s;
        busy_r <= 1'b1;
      end else if (wrap_s) begin
        busy_r <= 1'b0;
      end
      if (wrap_s) begin
        map_r <= vecteur_map;
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= {BW{1'b0}};
          phase_r     <= ~phase_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BW'(1);
        end
      end
    end
  end

  // Stage 0 decode from the current counter state and active timing.
  always_comb begin
    hs_s      = (h_cnt_r <= act_r.hs);
    vs_s      = (v_cnt_r <= act_r.vs);
    de_s      = (h_cnt_r >= act_r.hb) && (h_cnt_r < act_r.he) &&
                (v_cnt_r >= act_r.vb) && (v_cnt_r < act_r.ve);
    fs_s      = (h_cnt_r == {TW{1'b0}}) && (v_cnt_r == {TW{1'b0}});
    x_s       = h_cnt_r - act_r.hb;
    y_s       = v_cnt_r - act_r.vb;
    col_s     = x_s >> CELL_LOG2;
    row_s     = y_s >> CELL_LOG2;
    x_lo_s    = x_s[CELL_LOG2-1:0];
    y_lo_s    = y_s[CELL_LOG2-1:0];
    in_grid_s = (col_s < GW_T) && (row_s < GH_T);
    idx_s     = IW'({{TW{1'b0}}, row_s} * (2*TW)'(GRID_W) + {{TW{1'b0}}, col_s});
    if (in_grid_s) alive_s = map_r[idx_s];
    else           alive_s = 1'b0;
    edge_s    = (x_lo_s == {CELL_LOG2{1'b0}}) || (&x_lo_s) ||
                (y_lo_s == {CELL_LOG2{1'b0}}) || (&y_lo_s);
    // in_grid_s already rejects an off-grid cursor position.
    curs_s    = cursor_en && phase_r && in_grid_s &&
                (col_s == cursor_x) && (row_s == cursor_y) && edge_s;
  end

  // Stage 0 pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs0_r    <= 1'b0;
      vs0_r    <= 1'b0;
      de0_r    <= 1'b0;
      fs0_r    <= 1'b0;
      curs0_r  <= 1'b0;
      grid0_r  <= 1'b0;
      alive0_r <= 1'b0;
    end else begin
      hs0_r    <= hs_s;
      vs0_r    <= vs_s;
      de0_r    <= de_s;
      fs0_r    <= fs_s;
      curs0_r  <= curs_s;
      grid0_r  <= in_grid_s;
      alive0_r <= alive_s;
    end
  end

  // Colour priority: blanking, cursor outline, grid cell, background.
  always_comb begin
    rgb_s = 24'h000000;
    if (!de0_r)        rgb_s = 24'h000000;
    else if (curs0_r)  rgb_s = C_CURS;
    else if (grid0_r)  rgb_s = alive0_r ? C_ALIVE : C_DEAD;
    else               rgb_s = C_BG;
  end

  // Stage 1 output pins with sync polarity applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_de      <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= ~(hs0_r ^ SYNC_POL);
      vga_vs      <= ~(vs0_r ^ SYNC_POL);
      vga_de      <= de0_r;
      {vga_r, vga_g, vga_b} <= rgb_s;
      frame_start <= fs0_r;
    end
  end

endmodule
